pwm_capture: RTL

- Measurement counterpart to the team's PWM generator. Samples an external or looped-back PWM signal and reports its period and high time in clock cycles.
- Detects stuck-low and stuck-high inputs via a timeout.
- Sits behind the same Avalon-MM register slave as the generator. Results are latched for CPU readback.
- Widths match the generator, so a loopback reports exactly what the generator was programmed with.

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_sync_edge.sv | 36 +++
 rtl/pwm_capture.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM generator / capture pair.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// PWM_CNT_WIDTH is common to generator and capture, so a looped-back signal
// is reported with exactly the programmed values. PWM_CNT_MAX is the
// counter saturation value. The pwm_cap_state_t members are the capture FSM
// encodings.
package pwm_pkg;

  localparam int PWM_CNT_WIDTH = 16;

  localparam logic [PWM_CNT_WIDTH-1:0] PWM_CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_RUN     = 2'd1,
    ST_TIMEOUT = 2'd2
  } pwm_cap_state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronizes an asynchronous level into the clock domain and flags rising edges.
// Latency: input change to s_in is SYNC_STAGES cycles; rise is combinational from s_in.
// Backpressure: none; the block samples every cycle.
//
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   async_sig     asynchronous input level
//   s_in          synchronized level
//   rise          high for one cycle when s_in goes 0 -> 1
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_sig,
  output logic s_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_sig};
      s_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_in = sync_q[SYNC_STAGES-1];
  assign rise = s_in & ~s_prev;

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM period and high time in clock cycles; flags stuck inputs via timeout.
// Latency: pwm_in rise to measure_valid is SYNC_STAGES+1 cycles; results valid with the pulse.
// Backpressure: none; measure_valid is a one-cycle pulse and results are held for readback.
//
// Ports:
//   clock, reset     rising-edge clock, synchronous active-high reset
//   enable           0 holds the block in ACQUIRE with counters cleared
//   pwm_in           asynchronous PWM input
//   measured_period  cycles between the last two rising edges
//   measured_high    high cycles within that period
//   measure_valid    one-cycle pulse when new results are latched
//   timeout          no rising edge seen for 2^WIDTH-1 cycles
//   stuck_level      synchronized input level captured on timeout entry
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH       = PWM_CNT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] measured_period,
  output logic [WIDTH-1:0] measured_high,
  output logic             measure_valid,
  output logic             timeout,
  output logic             stuck_level
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  pwm_cap_state_t   state, state_nxt;
  logic [WIDTH-1:0] period_cnt, period_nxt;
  logic [WIDTH-1:0] high_cnt, high_nxt;
  logic             s_in, rise;
  logic             at_max;
  logic             latch_meas;
  logic             enter_to;

  pwm_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clock     (clock),
    .reset     (reset),
    .async_sig (pwm_in),
    .s_in      (s_in),
    .rise      (rise)
  );

  // A full 2^WIDTH-1 cycle period is still measurable: the stall is only
  // declared when the counter already sits at max and no rise arrives.
  assign at_max = (period_cnt == CNT_MAX);

  // Both counters saturate together, so high_cnt can never pass period_cnt.
  always_comb begin
    period_nxt = period_cnt;
    high_nxt   = high_cnt;
    if (!enable) begin
      period_nxt = '0;
      high_nxt   = '0;
    end else if (rise) begin
      period_nxt = CNT_ONE;
      high_nxt   = CNT_ONE;
    end else begin
      if (!at_max) begin
        period_nxt = period_cnt + CNT_ONE;
      end
      if (s_in && (high_cnt != CNT_MAX)) begin
        high_nxt = high_cnt + CNT_ONE;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    latch_meas = 1'b0;
    enter_to   = 1'b0;
    if (!enable) begin
      state_nxt = ST_ACQUIRE;
    end else begin
      case (state)
        // First (partial) period is never reported.
        ST_ACQUIRE: begin
          if (rise) begin
            state_nxt = ST_RUN;
          end else if (at_max) begin
            state_nxt = ST_TIMEOUT;
            enter_to  = 1'b1;
          end
        end
        ST_RUN: begin
          if (rise) begin
            latch_meas = 1'b1;
          end else if (at_max) begin
            state_nxt = ST_TIMEOUT;
            enter_to  = 1'b1;
          end
        end
        // The period following a stall is untrusted, so leaving TIMEOUT
        // restarts measurement without a valid pulse.
        ST_TIMEOUT: begin
          if (rise) begin
            state_nxt = ST_RUN;
          end
        end
        default: begin
          state_nxt = ST_ACQUIRE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_ACQUIRE;
      period_cnt      <= '0;
      high_cnt        <= '0;
      measured_period <= '0;
      measured_high   <= '0;
      measure_valid   <= 1'b0;
      timeout         <= 1'b0;
      stuck_level     <= 1'b0;
    end else begin
      state         <= state_nxt;
      period_cnt    <= period_nxt;
      high_cnt      <= high_nxt;
      measure_valid <= latch_meas;
      // TIMEOUT is only left on a rise or via enable=0, so the flag simply
      // mirrors the next state.
      timeout       <= (state_nxt == ST_TIMEOUT);
      if (latch_meas) begin
        measured_period <= period_cnt;
        measured_high   <= high_cnt;
      end else if (enter_to) begin
        measured_period <= '0;
        measured_high   <= '0;
      end
      if (enter_to) begin
        stuck_level <= s_in;
      end
    end
  end

endmodule
